// File: rtl/cva6_region_pkg.sv
// Shared types, word offsets and helpers for the runtime region rule unit.
package cva6_region_pkg;

  localparam int unsigned MaxRules = 16;

  // Register word offsets within a rule (cfg_addr_i[3:2]).
  localparam logic [1:0] WordBase  = 2'd0;
  localparam logic [1:0] WordLen   = 2'd1;
  localparam logic [1:0] WordCtrl  = 2'd2;
  localparam logic [1:0] WordStats = 2'd3;

  typedef struct packed {
    logic exec;
    logic nonidem;
    logic cached;
  } rule_attr_t;

  typedef struct packed {
    logic lock;
    logic exec;
    logic nonidem;
    logic cached;
    logic en;
  } rule_ctrl_t;

  // Register image: bit7 lock, bit3 exec, bit2 nonidem, bit1 cached, bit0 en.
  function automatic rule_ctrl_t word_to_ctrl(logic [63:0] w);
    rule_ctrl_t c;
    c.lock    = w[7];
    c.exec    = w[3];
    c.nonidem = w[2];
    c.cached  = w[1];
    c.en      = w[0];
    return c;
  endfunction

  function automatic logic [63:0] ctrl_to_word(rule_ctrl_t c);
    logic [63:0] w;
    w    = '0;
    w[7] = c.lock;
    w[3] = c.exec;
    w[2] = c.nonidem;
    w[1] = c.cached;
    w[0] = c.en;
    return w;
  endfunction

  function automatic rule_attr_t ctrl_attr(rule_ctrl_t c);
    rule_attr_t a;
    a.exec    = c.exec;
    a.nonidem = c.nonidem;
    a.cached  = c.cached;
    return a;
  endfunction

endpackage

// File: rtl/cva6_region_match.sv
// Combinational match of one lookup address against all rules with lowest-index priority.
module cva6_region_match
  import cva6_region_pkg::*;
#(
  parameter int unsigned NrRules     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter rule_attr_t  DefaultAttr = '0
) (
  input  logic [AddrWidth-1:0]              addr_i,
  input  logic [NrRules-1:0][AddrWidth-1:0] base_i,
  input  logic [NrRules-1:0][AddrWidth-1:0] len_i,
  input  logic [NrRules-1:0]                en_i,
  input  rule_attr_t [NrRules-1:0]          attr_i,
  output logic                              hit_o,
  output logic [3:0]                        idx_o,
  output rule_attr_t                        attr_o
);

  logic [NrRules-1:0] match;

  // Offset compare keeps a region that runs past the top of the address space from wrapping.
  always_comb begin
    match = '0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      match[r] = en_i[r] && (len_i[r] != '0) && (addr_i >= base_i[r]) &&
                 ((addr_i - base_i[r]) < len_i[r]);
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    attr_o = DefaultAttr;
    for (int r = int'(NrRules) - 1; r >= 0; r--) begin
      if (match[r]) begin
        hit_o  = 1'b1;
        idx_o  = 4'(r);
        attr_o = attr_i[r];
      end
    end
  end

endmodule

// File: rtl/cva6_region_rule_unit.sv
// Runtime-programmable region rule table with registered multi-port lookup.
// Optional per-rule hit counters are built when REGION_RULE_STATS_EN is defined.
module cva6_region_rule_unit
  import cva6_region_pkg::*;
#(
  parameter int unsigned                   NrRules       = 4,
  parameter int unsigned                   NrLookupPorts = 2,
  parameter int unsigned                   AddrWidth     = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLen    = '0,
  parameter rule_ctrl_t [NrRules-1:0]      RstCtrl       = '0,
  parameter rule_attr_t                    DefaultAttr   = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 cfg_req_i,
  input  logic                                 cfg_we_i,
  input  logic [7:0]                           cfg_addr_i,
  input  logic [63:0]                          cfg_wdata_i,
  output logic                                 cfg_rvalid_o,
  output logic [63:0]                          cfg_rdata_o,
  output logic                                 cfg_err_o,
  input  logic [NrLookupPorts-1:0]             lkp_valid_i,
  input  logic [NrLookupPorts*AddrWidth-1:0]   lkp_addr_i,
  output logic [NrLookupPorts-1:0]             lkp_valid_o,
  output logic [NrLookupPorts-1:0]             lkp_hit_o,
  output logic [NrLookupPorts*4-1:0]           lkp_idx_o,
  output logic [NrLookupPorts*3-1:0]           lkp_attr_o
);

  logic [NrRules-1:0][AddrWidth-1:0] base_q, base_d, len_q, len_d;
  rule_ctrl_t [NrRules-1:0]          ctrl_q, ctrl_d;

  logic [3:0]  cfg_idx;
  logic [1:0]  cfg_word;
  logic        idx_ok, rule_locked, cfg_err, wr_ok;
  logic [63:0] rd_val;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic        unused_addr;

  logic [NrRules-1:0]                  rule_en;
  rule_attr_t [NrRules-1:0]            rule_attr;
  logic [NrLookupPorts-1:0]            m_hit;
  logic [NrLookupPorts-1:0][3:0]       m_idx;
  rule_attr_t [NrLookupPorts-1:0]      m_attr;
  logic [NrLookupPorts-1:0]            lkp_valid_q, lkp_valid_d, lkp_hit_q, lkp_hit_d;
  logic [NrLookupPorts-1:0][3:0]       lkp_idx_q, lkp_idx_d;
  rule_attr_t [NrLookupPorts-1:0]      lkp_attr_q, lkp_attr_d;

`ifdef REGION_RULE_STATS_EN
  logic [NrRules-1:0][31:0] cnt_q, cnt_d;
  logic [NrRules-1:0]       cnt_clr;
  logic [32:0]              cnt_inc, cnt_sum;
`endif

  assign cfg_idx     = cfg_addr_i[7:4];
  assign cfg_word    = cfg_addr_i[3:2];
  assign unused_addr = ^cfg_addr_i[1:0];

  // Decode the addressed rule: existence, lock state and read value.
  always_comb begin
    idx_ok      = 1'b0;
    rule_locked = 1'b0;
    rd_val      = '0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      if (cfg_idx == 4'(r)) begin
        idx_ok      = 1'b1;
        rule_locked = ctrl_q[r].lock;
        case (cfg_word)
          WordBase: rd_val = 64'(base_q[r]);
          WordLen:  rd_val = 64'(len_q[r]);
          WordCtrl: rd_val = ctrl_to_word(ctrl_q[r]);
          default: begin
`ifdef REGION_RULE_STATS_EN
            rd_val = 64'(cnt_q[r]);
`else
            rd_val = '0;
`endif
          end
        endcase
      end
    end
    cfg_err = cfg_req_i && (!idx_ok || (cfg_we_i && rule_locked));
    wr_ok   = cfg_req_i && cfg_we_i && idx_ok && !rule_locked;
  end

  // Rule register writes; a write to the counter word only clears it.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    ctrl_d = ctrl_q;
`ifdef REGION_RULE_STATS_EN
    cnt_clr = '0;
`endif
    for (int unsigned r = 0; r < NrRules; r++) begin
      if (wr_ok && (cfg_idx == 4'(r))) begin
        case (cfg_word)
          WordBase: base_d[r] = cfg_wdata_i[AddrWidth-1:0];
          WordLen:  len_d[r]  = cfg_wdata_i[AddrWidth-1:0];
          WordCtrl: ctrl_d[r] = word_to_ctrl(cfg_wdata_i);
          default: begin
`ifdef REGION_RULE_STATS_EN
            cnt_clr[r] = 1'b1;
`endif
          end
        endcase
      end
    end
  end

  // Config response, presented one cycle after the request.
  always_comb begin
    rvalid_d = cfg_req_i;
    err_d    = cfg_err;
    rdata_d  = (cfg_req_i && !cfg_we_i && !cfg_err) ? rd_val : '0;
  end

  // Per-rule enable/attribute views for the matchers.
  always_comb begin
    for (int unsigned r = 0; r < NrRules; r++) begin
      rule_en[r]   = ctrl_q[r].en;
      rule_attr[r] = ctrl_attr(ctrl_q[r]);
    end
  end

  for (genvar p = 0; p < NrLookupPorts; p++) begin : g_port
    cva6_region_match #(
      .NrRules     (NrRules),
      .AddrWidth   (AddrWidth),
      .DefaultAttr (DefaultAttr)
    ) u_match (
      .addr_i (lkp_addr_i[p*AddrWidth +: AddrWidth]),
      .base_i (base_q),
      .len_i  (len_q),
      .en_i   (rule_en),
      .attr_i (rule_attr),
      .hit_o  (m_hit[p]),
      .idx_o  (m_idx[p]),
      .attr_o (m_attr[p])
    );
  end

  // Lookup result stage; idle ports output all zeros.
  always_comb begin
    for (int unsigned p = 0; p < NrLookupPorts; p++) begin
      lkp_valid_d[p] = lkp_valid_i[p];
      lkp_hit_d[p]   = lkp_valid_i[p] && m_hit[p];
      lkp_idx_d[p]   = lkp_valid_i[p] ? m_idx[p] : '0;
      lkp_attr_d[p]  = lkp_valid_i[p] ? m_attr[p] : '0;
    end
  end

  // State update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= RstBase;
      len_q       <= RstLen;
      ctrl_q      <= RstCtrl;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      lkp_valid_q <= '0;
      lkp_hit_q   <= '0;
      lkp_idx_q   <= '0;
      lkp_attr_q  <= '0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      ctrl_q      <= ctrl_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      lkp_valid_q <= lkp_valid_d;
      lkp_hit_q   <= lkp_hit_d;
      lkp_idx_q   <= lkp_idx_d;
      lkp_attr_q  <= lkp_attr_d;
    end
  end

`ifdef REGION_RULE_STATS_EN
  // Saturating hit counters; a clear in the same cycle as hits wins.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_inc = '0;
    cnt_sum = '0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      cnt_inc = '0;
      for (int unsigned p = 0; p < NrLookupPorts; p++) begin
        if (lkp_valid_i[p] && m_hit[p] && (m_idx[p] == 4'(r))) begin
          cnt_inc = cnt_inc + 33'd1;
        end
      end
      cnt_sum = {1'b0, cnt_q[r]} + cnt_inc;
      if (cnt_clr[r]) begin
        cnt_d[r] = '0;
      end else if (cnt_sum[32]) begin
        cnt_d[r] = '1;
      end else begin
        cnt_d[r] = cnt_sum[31:0];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;
  assign cfg_rdata_o  = rdata_q;
  assign lkp_valid_o  = lkp_valid_q;
  assign lkp_hit_o    = lkp_hit_q;
  assign lkp_idx_o    = lkp_idx_q;
  assign lkp_attr_o   = lkp_attr_q;

endmodule

// File: tb/tb_cva6_region_rule_unit.sv
// Directed and randomized bench for cva6_region_rule_unit against an interval-based model.
module tb_cva6_region_rule_unit;
  import cva6_region_pkg::*;

  localparam int NR = 4;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam logic [NR-1:0][AW-1:0] RB = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RL = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
  localparam logic [NR-1:0][4:0]    RC = {5'h00, 5'h00, 5'h00, 5'h03};
  localparam logic [2:0]            DEF = 3'b100;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_req, cfg_we;
  logic [7:0]        cfg_addr;
  logic [63:0]       cfg_wdata;
  logic              cfg_rvalid, cfg_err;
  logic [63:0]       cfg_rdata;
  logic [NP-1:0]     lkp_valid_in;
  logic [NP*AW-1:0]  lkp_addr;
  logic [NP-1:0]     lkp_valid_out, lkp_hit;
  logic [NP*4-1:0]   lkp_idx;
  logic [NP*3-1:0]   lkp_attr;

  int checks = 0;
  int errors = 0;

  // Model state: ctrl kept as its 8-bit register image.
  logic [63:0] mb[NR];
  logic [63:0] ml[NR];
  logic [7:0]  mc[NR];
  logic [31:0] mcnt[NR];

  cva6_region_rule_unit #(
    .NrRules       (NR),
    .NrLookupPorts (NP),
    .AddrWidth     (AW),
    .RstBase       (RB),
    .RstLen        (RL),
    .RstCtrl       (RC),
    .DefaultAttr   (DEF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .lkp_valid_i  (lkp_valid_in),
    .lkp_addr_i   (lkp_addr),
    .lkp_valid_o  (lkp_valid_out),
    .lkp_hit_o    (lkp_hit),
    .lkp_idx_o    (lkp_idx),
    .lkp_attr_o   (lkp_attr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mb[i]   = RB[i];
      ml[i]   = RL[i];
      mc[i]   = {RC[i][4], 3'b000, RC[i][3:0]};
      mcnt[i] = '0;
    end
  endtask

  // A rule covers the half-open interval [base, base+len) computed without wrap.
  task automatic model_lkp(input logic [63:0] a, output logic h, output logic [3:0] ix,
                           output logic [2:0] at);
    logic [64:0] lo, hi;
    h  = 1'b0;
    ix = '0;
    at = DEF;
    for (int i = 0; i < NR; i++) begin
      lo = {1'b0, mb[i]};
      hi = lo + {1'b0, ml[i]};
      if (!h && mc[i][0] && ({1'b0, a} >= lo) && ({1'b0, a} < hi)) begin
        h  = 1'b1;
        ix = 4'(i);
        at = mc[i][3:1];
      end
    end
  endtask

  function automatic logic [63:0] pick_addr();
    int j;
    j = $urandom_range(0, NR - 1);
    case ($urandom_range(0, 4))
      0:       return 64'($urandom_range(0, 'h4000));
      1:       return mb[j] + ml[j] - 64'($urandom_range(0, 1));
      2:       return mb[j] - 64'($urandom_range(0, 1));
      3:       return {$urandom, $urandom};
      default: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 'h10));
    endcase
  endfunction

  // One clock of stimulus: optional config access plus lookups, then check the registered results.
  task automatic step(input bit req, input bit we, input int idx, input int word,
                      input logic [63:0] wd, input bit v0, input logic [63:0] a0,
                      input bit v1, input logic [63:0] a1, input string tag);
    logic       eh[NP];
    logic [3:0] ei[NP];
    logic [2:0] ea[NP];
    bit         ev[NP];
    logic [63:0] erd;
    logic        eerr;
    cfg_req      = req;
    cfg_we       = we;
    cfg_addr     = {4'(idx), 2'(word), 2'b00};
    cfg_wdata    = wd;
    lkp_valid_in = {v1, v0};
    lkp_addr     = {a1, a0};
    ev[0] = v0;
    ev[1] = v1;
    model_lkp(a0, eh[0], ei[0], ea[0]);
    model_lkp(a1, eh[1], ei[1], ea[1]);
    erd  = '0;
    eerr = 1'b0;
    if (req) begin
      if (idx >= NR) eerr = 1'b1;
      else if (we && mc[idx][7]) eerr = 1'b1;
      else if (!we) begin
        case (word)
          0: erd = mb[idx];
          1: erd = ml[idx];
          2: erd = {56'b0, mc[idx]};
          default: begin
`ifdef REGION_RULE_STATS_EN
            erd = {32'b0, mcnt[idx]};
`endif
          end
        endcase
      end
    end
`ifdef REGION_RULE_STATS_EN
    for (int p = 0; p < NP; p++) begin
      if (ev[p] && eh[p] && (mcnt[ei[p]] != 32'hFFFF_FFFF)) mcnt[ei[p]] = mcnt[ei[p]] + 1;
    end
`endif
    if (req && we && !eerr) begin
      case (word)
        0: mb[idx] = wd;
        1: ml[idx] = wd;
        2: mc[idx] = {wd[7], 3'b000, wd[3:0]};
        default: mcnt[idx] = '0;
      endcase
    end
    @(posedge clk);
    #1;
    cfg_req      = 1'b0;
    cfg_we       = 1'b0;
    lkp_valid_in = '0;
    chk({tag, ".rvalid"}, 64'(cfg_rvalid), 64'(req));
    chk({tag, ".err"}, 64'(cfg_err), 64'(eerr));
    chk({tag, ".rdata"}, cfg_rdata, erd);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s.p%0d.valid", tag, p), 64'(lkp_valid_out[p]), 64'(ev[p]));
      chk($sformatf("%s.p%0d.hit", tag, p), 64'(lkp_hit[p]), 64'(ev[p] && eh[p]));
      chk($sformatf("%s.p%0d.idx", tag, p), 64'(lkp_idx[p*4 +: 4]), ev[p] ? 64'(ei[p]) : 64'd0);
      chk($sformatf("%s.p%0d.attr", tag, p), 64'(lkp_attr[p*3 +: 3]),
          ev[p] ? 64'(ea[p]) : 64'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_req      = 1'b1;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    lkp_valid_in = '1;
    lkp_addr     = {64'h8000_1000, 64'h8000_1000};
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rvalid", 64'(cfg_rvalid), 64'd0);
    chk("reset.rdata", cfg_rdata, 64'd0);
    chk("reset.lkp_valid", 64'(lkp_valid_out), 64'd0);
    chk("reset.lkp_hit", 64'(lkp_hit), 64'd0);
    chk("reset.lkp_attr", 64'(lkp_attr), 64'd0);
    rst          = 1'b0;
    cfg_req      = 1'b0;
    lkp_valid_in = '0;
    model_reset();

    // Reset-programmed rule 0, and a miss returning the default attributes.
    step(0, 0, 0, 0, 0, 1, 64'h8000_1000, 1, 64'h1000, "rstdef");
    chk("rstdef.lit.hit", 64'(lkp_hit[0]), 64'd1);
    chk("rstdef.lit.attr", 64'(lkp_attr[2:0]), 64'b001);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rd_ctrl0_idle");
    step(1, 0, 0, 2, 0, 0, 0, 0, 0, "rd_ctrl0");
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, "rd_badidx");

    // Same-cycle write and lookup: the lookup sees the old length.
    step(1, 1, 0, 0, 64'h1000, 1, 64'h8000_1000, 0, 0, "wr_base0");
    step(0, 0, 0, 0, 0, 1, 64'h1000, 0, 0, "hit_new_base0");
    step(1, 1, 0, 1, 64'h0, 1, 64'h1000, 0, 0, "same_cycle");
    chk("same_cycle.lit.hit", 64'(lkp_hit[0]), 64'd1);
    step(0, 0, 0, 0, 0, 1, 64'h1000, 0, 0, "after_len0");
    chk("after_len0.lit.hit", 64'(lkp_hit[0]), 64'd0);

    // Region boundaries on rule 3.
    step(1, 1, 3, 0, 64'h1000, 0, 0, 0, 0, "wr_base3");
    step(1, 1, 3, 1, 64'h1000, 0, 0, 0, 0, "wr_len3");
    step(1, 1, 3, 2, 64'h09, 0, 0, 0, 0, "wr_ctrl3");
    step(0, 0, 0, 0, 0, 1, 64'hFFF, 1, 64'h1000, "bound_lo");
    step(0, 0, 0, 0, 0, 1, 64'h1FFF, 1, 64'h2000, "bound_hi");

    // A region running off the top of the address space must not wrap.
    step(1, 1, 2, 0, 64'hFFFF_FFFF_FFFF_F000, 0, 0, 0, 0, "wr_base2_top");
    step(1, 1, 2, 1, 64'h2000, 0, 0, 0, 0, "wr_len2_top");
    step(1, 1, 2, 2, 64'h03, 0, 0, 0, 0, "wr_ctrl2_top");
    step(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h800, "nowrap");

    // Overlap: lowest index wins.
    step(1, 1, 1, 0, 64'h0, 0, 0, 0, 0, "wr_base1");
    step(1, 1, 1, 1, 64'h10000, 0, 0, 0, 0, "wr_len1");
    step(1, 1, 1, 2, 64'h05, 0, 0, 0, 0, "wr_ctrl1");
    step(1, 1, 2, 0, 64'h8000, 0, 0, 0, 0, "wr_base2");
    step(1, 1, 2, 1, 64'h1000, 0, 0, 0, 0, "wr_len2");
    step(0, 0, 0, 0, 0, 1, 64'h8800, 1, 64'h8800, "overlap");
    chk("overlap.lit.idx", 64'(lkp_idx[3:0]), 64'd1);
    chk("overlap.lit.attr", 64'(lkp_attr[2:0]), 64'b010);

    // Lock rule 0 (lock set alongside en is accepted), then writes are refused.
    step(1, 1, 0, 2, 64'h81, 0, 0, 0, 0, "lock0");
    step(1, 1, 0, 0, 64'h0, 0, 0, 0, 0, "locked_wr");
    chk("locked_wr.lit.err", 64'(cfg_err), 64'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "locked_rd");
    chk("locked_rd.lit.base", cfg_rdata, 64'h1000);
    step(1, 1, 0, 3, 64'h5, 0, 0, 0, 0, "locked_wr_w3");
    step(1, 1, 1, 3, 64'h5, 0, 0, 0, 0, "unlocked_wr_w3");

    // Hit counter on rule 3 (disable rule 1 so rule 3 wins).
    step(1, 1, 1, 2, 64'h00, 0, 0, 0, 0, "dis1");
    step(1, 1, 3, 3, 64'h0, 0, 0, 0, 0, "clr3");
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1, 64'h1800, 1, 64'h1A00, "stat_hit");
    step(1, 0, 3, 3, 0, 0, 0, 0, 0, "rd_cnt3");
`ifdef REGION_RULE_STATS_EN
    chk("rd_cnt3.lit", cfg_rdata, 64'd10);
`endif
    step(1, 1, 3, 3, 64'hDEAD, 0, 0, 0, 0, "clr3b");
    step(1, 0, 3, 3, 0, 0, 0, 0, 0, "rd_cnt3_clr");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int          r, w;
      bit          req, we;
      logic [63:0] wd;
      r   = $urandom_range(0, 5);
      w   = $urandom_range(0, 3);
      req = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      case (w)
        0: wd = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_F000
                                            : 64'($urandom_range(0, 'h3000));
        1: wd = 64'($urandom_range(0, 'h2000));
        2: wd = 64'($urandom_range(0, 255)) & 64'h7F;
        default: wd = {$urandom, $urandom};
      endcase
      step(req, we, r, w, wd, 1'($urandom_range(0, 1)), pick_addr(),
           1'($urandom_range(0, 1)), pick_addr(), "rand");
    end

    // Reset during an access drops its response and restores the reset rules.
    rst      = 1'b1;
    cfg_req  = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = 8'h00;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cfg_req = 1'b0;
    chk("rst_mid.rvalid", 64'(cfg_rvalid), 64'd0);
    model_reset();
    step(1, 1, 0, 0, 64'h4000, 1, 64'h8000_1000, 0, 0, "post_rst_wr");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
